generador_sync_vga: RTL and testbench
=====================================

# generador_sync_vga

Parametrised VGA timing generator that replaces the separate counter plus combinational VSync decoder with a single self-contained block. It owns the pixel-rate prescaler, the horizontal and vertical counters, and registered HSync, VSync and video-enable outputs. It also emits pixel coordinates and line/frame strobes. It sits between the system clock and the pixel/RGB generation logic. With default parameters and a 50 MHz clock it reproduces the legacy 840 000-clock frame.

## Interface
Parameters:
- CLK_DIV, 2: system clocks per pixel (≥1)
- H_ACTIVE, 640: visible pixels per line
- H_FP, 16: horizontal front porch, in pixels
- H_SYNC, 96: horizontal sync width, in pixels
- H_BP, 48: horizontal back porch, in pixels
- V_ACTIVE, 480: visible lines per frame
- V_FP, 10: vertical front porch, in lines
- V_SYNC, 2: vertical sync width, in lines
- V_BP, 33: vertical back porch, in lines
- HSYNC_POL, 0: asserted level of hsync
- VSYNC_POL, 0: asserted level of vsync
- X_W, 10 / Y_W, 10: coordinate widths; must satisfy 2^X_W ≥ H_TOTAL and 2^Y_W ≥ V_TOTAL

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous reset, active-low; one clock, no other clock domains
- pixel_tick  out  1  one-clock pulse per pixel period
- hsync  out  1  horizontal sync, registered
- vsync  out  1  vertical sync, registered
- video_on  out  1  high while in the active area, registered
- pixel_x  out  X_W  horizontal count, 0..H_TOTAL-1
- pixel_y  out  Y_W  vertical count, 0..V_TOTAL-1
- line_start  out  1  one-clock pulse when pixel_x wraps to 0
- frame_start  out  1  one-clock pulse when (pixel_x, pixel_y) wraps to (0,0)

## Operation
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Segment order on each axis: active, then front porch, then sync, then back porch.
- Prescaler `div` counts 0..CLK_DIV-1 and wraps. pixel_tick = (div == CLK_DIV-1); with CLK_DIV=1, pixel_tick is constantly 1.
- On a pixel_tick clock, pixel_x increments. At H_TOTAL-1 it wraps to 0, and pixel_y increments. At V_TOTAL-1 on that wrap, pixel_y wraps to 0.
- Decode is performed on the next-state counter values and registered on the same edge, so hsync, vsync and video_on always correspond to the current pixel_x/pixel_y (zero-cycle skew).
- hsync = HSYNC_POL when H_ACTIVE+H_FP ≤ pixel_x < H_ACTIVE+H_FP+H_SYNC; otherwise ~HSYNC_POL.
- vsync = VSYNC_POL when V_ACTIVE+V_FP ≤ pixel_y < V_ACTIVE+V_FP+V_SYNC; otherwise ~VSYNC_POL. vsync changes only together with pixel_y.
- video_on = (pixel_x < H_ACTIVE) && (pixel_y < V_ACTIVE).
- line_start and frame_start are registered. They are high for exactly the one clock following the wrap edge, coincident with the new count. frame_start implies line_start.
- Counter arithmetic is unsigned. Comparisons are done at 32-bit parameter width, with no truncation before compare.

## Timing
- Reset values (asynchronous, immediate): div=0, pixel_x=0, pixel_y=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL, video_on=1, line_start=0, frame_start=0. pixel_tick=1 only if CLK_DIV=1.
- Reset does not generate line_start or frame_start. The first frame_start occurs after a full frame: H_TOTAL·V_TOTAL·CLK_DIV clocks after rst_n deasserts.
- Reset mid-frame: all state returns to the reset values on the rst_n falling edge, regardless of clk. Counting restarts from (0,0) on the first rising edge with rst_n high.
- Periods: line = H_TOTAL·CLK_DIV clocks; frame = H_TOTAL·V_TOTAL·CLK_DIV clocks. Defaults: 1600 and 840 000.
- Latency: zero between the counters and the decoded outputs. A downstream consumer registering RGB from pixel_x/pixel_y adds its own cycle.

## Test plan
- Reset: hold rst_n=0 and toggle clk → pixel_x=0, pixel_y=0, hsync=1, vsync=1, video_on=1, strobes 0. Assert rst_n asynchronously between edges → outputs change without a clk edge.
- Horizontal, defaults: hsync goes 0 at pixel_x=656, i.e. 1312 clocks after reset release; it stays low for 192 clocks; line_start pulses every 1600 clocks; video_on falls at pixel_x=640.
- Vertical, defaults: vsync low exactly while pixel_y ∈ {490,491} (3200 clocks). First frame_start at 840 000 clocks after reset; the next at 1 680 000.
- Polarity: HSYNC_POL=1, VSYNC_POL=1 → sync levels inverted, reset levels 0, all timing identical.
- Small config: CLK_DIV=1, H=4/1/2/1, V=3/1/1/1 → pixel_tick constant 1, line 8 clocks, frame 48 clocks. hsync asserted at pixel_x 5..6; video_on high for 12 clocks per frame.
- Reset mid-frame: assert rst_n=0 at pixel_y=300 → immediate (0,0). After release, no frame_start until 840 000 clocks.

Source files
------------

// File: rtl/generador_sync_vga.sv
// VGA timing generator: pixel prescaler, h/v counters, registered sync/video_on/strobes.
// Decoded outputs are computed from next-state counts, so they carry zero skew versus pixel_x/pixel_y.
module generador_sync_vga #(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0,
  parameter int unsigned X_W       = 10,
  parameter int unsigned Y_W       = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  output logic           pixel_tick,
  output logic           hsync,
  output logic           vsync,
  output logic           video_on,
  output logic [X_W-1:0] pixel_x,
  output logic [Y_W-1:0] pixel_y,
  output logic           line_start,
  output logic           frame_start
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div, div_nxt;
  logic [X_W-1:0]   x_nxt;
  logic [Y_W-1:0]   y_nxt;
  logic             hs_nxt, vs_nxt, von_nxt, ls_nxt, fs_nxt;

  assign pixel_tick = (32'(div) == CLK_DIV - 32'd1);

  always_comb begin
    div_nxt = div;
    x_nxt   = pixel_x;
    y_nxt   = pixel_y;
    ls_nxt  = 1'b0;
    fs_nxt  = 1'b0;
    if (pixel_tick) begin
      div_nxt = '0;
      if (32'(pixel_x) == H_TOTAL - 32'd1) begin
        x_nxt  = '0;
        ls_nxt = 1'b1;
        if (32'(pixel_y) == V_TOTAL - 32'd1) begin
          y_nxt  = '0;
          fs_nxt = 1'b1;
        end else begin
          y_nxt = pixel_y + 1'b1;
        end
      end else begin
        x_nxt = pixel_x + 1'b1;
      end
    end else begin
      div_nxt = div + 1'b1;
    end

    // Decode the values the counters are about to take, not the current ones.
    hs_nxt  = ((32'(x_nxt) >= HS_START) && (32'(x_nxt) < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
    vs_nxt  = ((32'(y_nxt) >= VS_START) && (32'(y_nxt) < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
    von_nxt = (32'(x_nxt) < H_ACTIVE) && (32'(y_nxt) < V_ACTIVE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div         <= '0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      video_on    <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div         <= div_nxt;
      pixel_x     <= x_nxt;
      pixel_y     <= y_nxt;
      hsync       <= hs_nxt;
      vsync       <= vs_nxt;
      video_on    <= von_nxt;
      line_start  <= ls_nxt;
      frame_start <= fs_nxt;
    end
  end

endmodule

// File: tb/tb_generador_sync_vga.sv
// Bench for generador_sync_vga: three configurations (small/div2, small/div1/inverted polarity, defaults).
// A closed-form timing model feeds per-cycle expectations into queues; a negedge monitor compares.
module tb_generador_sync_vga;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int k = 0;

  typedef struct packed {
    logic        tick;
    logic        hs;
    logic        vs;
    logic        von;
    logic        ls;
    logic        fs;
    logic [31:0] x;
    logic [31:0] y;
  } obs_t;

  obs_t qa[$];
  obs_t qb[$];
  obs_t qc[$];

  logic       a_tick, a_hs, a_vs, a_von, a_ls, a_fs;
  logic [3:0] a_x, a_y;
  logic       b_tick, b_hs, b_vs, b_von, b_ls, b_fs;
  logic [3:0] b_x, b_y;
  logic       c_tick, c_hs, c_vs, c_von, c_ls, c_fs;
  logic [9:0] c_x, c_y;

  generador_sync_vga #(
    .CLK_DIV(2), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .X_W(4), .Y_W(4)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .pixel_tick(a_tick), .hsync(a_hs), .vsync(a_vs),
    .video_on(a_von), .pixel_x(a_x), .pixel_y(a_y), .line_start(a_ls), .frame_start(a_fs)
  );

  generador_sync_vga #(
    .CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .X_W(4), .Y_W(4)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .pixel_tick(b_tick), .hsync(b_hs), .vsync(b_vs),
    .video_on(b_von), .pixel_x(b_x), .pixel_y(b_y), .line_start(b_ls), .frame_start(b_fs)
  );

  generador_sync_vga dut_c (
    .clk(clk), .rst_n(rst_n), .pixel_tick(c_tick), .hsync(c_hs), .vsync(c_vs),
    .video_on(c_von), .pixel_x(c_x), .pixel_y(c_y), .line_start(c_ls), .frame_start(c_fs)
  );

  // Expected outputs after k rising edges with rst_n high (k=0 is the reset state).
  function automatic obs_t model(input int kk, input int d,
                                 input int ha, input int hf, input int hsw, input int hb,
                                 input int va, input int vf, input int vsw, input int vb,
                                 input bit hp, input bit vp);
    obs_t o;
    int p, ht, vt, x, y;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    p  = kk / d;
    x  = p % ht;
    y  = (p / ht) % vt;
    o.tick = ((kk % d) == d - 1);
    o.hs   = (x >= ha + hf && x < ha + hf + hsw) ? hp : !hp;
    o.vs   = (y >= va + vf && y < va + vf + vsw) ? vp : !vp;
    o.von  = (x < ha) && (y < va);
    o.ls   = (kk > 0) && ((kk % d) == 0) && (x == 0);
    o.fs   = o.ls && (y == 0);
    o.x    = 32'(x);
    o.y    = 32'(y);
    return o;
  endfunction

  function automatic obs_t mk(input logic t, input logic hs, input logic vs, input logic von,
                              input logic ls, input logic fs, input int x, input int y);
    obs_t o;
    o.tick = t; o.hs = hs; o.vs = vs; o.von = von; o.ls = ls; o.fs = fs;
    o.x = 32'(x); o.y = 32'(y);
    return o;
  endfunction

  task automatic cmp(input string tag, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s k=%0d got tick=%b hs=%b vs=%b von=%b ls=%b fs=%b x=%0d y=%0d want tick=%b hs=%b vs=%b von=%b ls=%b fs=%b x=%0d y=%0d",
               tag, k, act.tick, act.hs, act.vs, act.von, act.ls, act.fs, act.x, act.y,
               exp.tick, exp.hs, exp.vs, exp.von, exp.ls, exp.fs, exp.x, exp.y);
    end
  endtask

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s k=%0d got=%0d want=%0d", tag, k, act, exp);
    end
  endtask

  // Producer: one expectation per clock per DUT.
  always @(posedge clk) begin
    #1;
    if (!rst_n) k = 0;
    else        k++;
    qa.push_back(model(k, 2, 4, 1, 2, 1, 3, 1, 1, 1, 1'b0, 1'b0));
    qb.push_back(model(k, 1, 4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1));
    qc.push_back(model(k, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0));
  end

  // Monitor: pops and compares away from the active edge.
  always @(negedge clk) begin
    if (qa.size() > 0) cmp("sb_a", mk(a_tick, a_hs, a_vs, a_von, a_ls, a_fs, int'(a_x), int'(a_y)), qa.pop_front());
    if (qb.size() > 0) cmp("sb_b", mk(b_tick, b_hs, b_vs, b_von, b_ls, b_fs, int'(b_x), int'(b_y)), qb.pop_front());
    if (qc.size() > 0) cmp("sb_c", mk(c_tick, c_hs, c_vs, c_von, c_ls, c_fs, int'(c_x), int'(c_y)), qc.pop_front());
  end

  task automatic at_k(input int target);
    int n;
    n = 0;
    while (k != target && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (k != target) begin
      checks++;
      failures++;
      $display("FAIL wait_k got=%0d want=%0d", k, target);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_c_x", int'(c_x), 0);
    chk("rst_c_hs", c_hs, 1);
    chk("rst_c_vs", c_vs, 1);
    chk("rst_c_von", c_von, 1);
    chk("rst_c_ls", c_ls, 0);
    chk("rst_b_tick", b_tick, 1);
    chk("rst_b_hs", b_hs, 0);
    chk("rst_a_tick", a_tick, 0);
    #2 rst_n = 1'b1;

    at_k(10); chk("a_hs_k10", a_hs, 0); chk("b_hs_k10", b_hs, 0); chk("b_von_k10", b_von, 1);
    at_k(14); chk("a_hs_k14", a_hs, 1); chk("b_hs_k14", b_hs, 1);
    at_k(16); chk("a_ls_k16", a_ls, 1); chk("a_fs_k16", a_fs, 0); chk("a_y_k16", int'(a_y), 1);
              chk("b_y_k16", int'(b_y), 2);
    at_k(32); chk("b_vs_k32", b_vs, 1);
    at_k(47); chk("b_fs_k47", b_fs, 0); chk("b_tick_k47", b_tick, 1);
    at_k(48); chk("b_fs_k48", b_fs, 1); chk("b_ls_k48", b_ls, 1); chk("b_x_k48", int'(b_x), 0);
    at_k(64); chk("a_vs_k64", a_vs, 0); chk("a_y_k64", int'(a_y), 4);
    at_k(70); chk("a_x_k70", int'(a_x), 3);

    // Asynchronous reset between edges: outputs must clear with no clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("arst_a_x", int'(a_x), 0);
    chk("arst_a_y", int'(a_y), 0);
    chk("arst_a_vs", a_vs, 1);
    chk("arst_a_von", a_von, 1);
    chk("arst_b_vs", b_vs, 0);
    chk("arst_c_x", int'(c_x), 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    at_k(95); chk("a_fs_k95", a_fs, 0);
    at_k(96); chk("a_fs_k96", a_fs, 1); chk("a_ls_k96", a_ls, 1);
    at_k(1279); chk("c_von_k1279", c_von, 1);
    at_k(1280); chk("c_von_k1280", c_von, 0); chk("c_x_k1280", int'(c_x), 640);
    at_k(1311); chk("c_hs_k1311", c_hs, 1);
    at_k(1312); chk("c_hs_k1312", c_hs, 0); chk("c_x_k1312", int'(c_x), 656);
    at_k(1503); chk("c_hs_k1503", c_hs, 0);
    at_k(1504); chk("c_hs_k1504", c_hs, 1);
    at_k(1599); chk("c_ls_k1599", c_ls, 0);
    at_k(1600); chk("c_ls_k1600", c_ls, 1); chk("c_x_k1600", int'(c_x), 0);
                chk("c_y_k1600", int'(c_y), 1); chk("c_fs_k1600", c_fs, 0);
    at_k(1601); chk("c_ls_k1601", c_ls, 0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
